// File: rtl/or4_resp_checker_if.sv
// Bundle for or4_resp_checker: stimulus vector, DUT response and run status.
// The stimulus/capture side uses the master modport, the checker the slave one.
interface or4_resp_checker_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic             in_valid;
    logic             a;
    logic             b;
    logic             c;
    logic             d;
    logic             e;
    logic             f;
    logic             g;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic [4:0]       vec_cnt;
    logic             first_err_valid;
    logic [3:0]       first_err_vec;
    logic             cov_full;

    modport master (
        output start, in_valid, a, b, c, d, e, f, g,
        input  busy, done, pass, err_cnt, vec_cnt,
               first_err_valid, first_err_vec, cov_full
    );

    modport slave (
        input  start, in_valid, a, b, c, d, e, f, g,
        output busy, done, pass, err_cnt, vec_cnt,
               first_err_valid, first_err_vec, cov_full
    );
endinterface

// File: rtl/or4_resp_checker.sv
// Response checker for the four-input OR block (E=a|b, F=c|d, G=a|b|c|d).
// Counts vectors and mismatches over a run of NVEC valid vectors, records the
// first failing input vector and reports a registered pass/fail verdict.
// Optional feature macro: OR4_CHK_COVER_EN -- when defined, a 16-bit input
// coverage mask is kept and the verdict also requires all patterns seen;
// when undefined, cov_full is tied high and the verdict is error count only.
//
// state  | meaning
// IDLE   | after reset, waiting for the first start
// RUN    | accepting valid vectors until NVEC have been checked
// DONE   | verdict held until the next start or reset
module or4_resp_checker #(
    parameter int NVEC  = 16,
    parameter int ERR_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    or4_resp_checker_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0]       LP_LAST    = 5'(NVEC - 1);
    localparam logic [ERR_W-1:0] LP_ERR_MAX = {ERR_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [4:0]       r_vec_cnt;
    logic [4:0]       w_vec_cnt_nxt;
    logic [ERR_W-1:0] r_err_cnt;
    logic [ERR_W-1:0] w_err_cnt_nxt;
    logic             r_fe_valid;
    logic             w_fe_valid_nxt;
    logic [3:0]       r_fe_vec;
    logic [3:0]       w_fe_vec_nxt;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             w_cov_full_nxt;

    logic [3:0]       w_vec;
    logic             w_mismatch;

    assign w_vec      = {bus.a, bus.b, bus.c, bus.d};
    assign w_mismatch = (bus.e != (bus.a | bus.b)) ||
                        (bus.f != (bus.c | bus.d)) ||
                        (bus.g != (|w_vec));

`ifdef OR4_CHK_COVER_EN
    logic [15:0] r_cov_mask;
    logic [15:0] w_cov_mask_nxt;
    logic        r_cov_full;
`endif

    // Next-state and next-value logic for the run state and accumulators.
    always_comb begin
        w_state_nxt    = r_state;
        w_vec_cnt_nxt  = r_vec_cnt;
        w_err_cnt_nxt  = r_err_cnt;
        w_fe_valid_nxt = r_fe_valid;
        w_fe_vec_nxt   = r_fe_vec;
`ifdef OR4_CHK_COVER_EN
        w_cov_mask_nxt = r_cov_mask;
`endif
        case (r_state)
            S_IDLE, S_DONE: begin
                // A vector presented together with start is not counted.
                if (bus.start) begin
                    w_state_nxt    = S_RUN;
                    w_vec_cnt_nxt  = '0;
                    w_err_cnt_nxt  = '0;
                    w_fe_valid_nxt = 1'b0;
                    w_fe_vec_nxt   = '0;
`ifdef OR4_CHK_COVER_EN
                    w_cov_mask_nxt = '0;
`endif
                end
            end
            S_RUN: begin
                if (bus.in_valid) begin
                    w_vec_cnt_nxt = r_vec_cnt + 5'd1;
`ifdef OR4_CHK_COVER_EN
                    w_cov_mask_nxt[w_vec] = 1'b1;
`endif
                    if (w_mismatch) begin
                        if (r_err_cnt != LP_ERR_MAX) begin
                            w_err_cnt_nxt = r_err_cnt + 1'b1;
                        end
                        if (!r_fe_valid) begin
                            w_fe_valid_nxt = 1'b1;
                            w_fe_vec_nxt   = w_vec;
                        end
                    end
                    if (r_vec_cnt == LP_LAST) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef OR4_CHK_COVER_EN
    assign w_cov_full_nxt = &w_cov_mask_nxt;
`else
    assign w_cov_full_nxt = 1'b1;
`endif

    // State, accumulators and status flags; status is derived from next values
    // so the verdict appears on the same edge that accepts the final vector.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_vec_cnt  <= '0;
            r_err_cnt  <= '0;
            r_fe_valid <= 1'b0;
            r_fe_vec   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_vec_cnt  <= w_vec_cnt_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
            r_fe_valid <= w_fe_valid_nxt;
            r_fe_vec   <= w_fe_vec_nxt;
            r_busy     <= (w_state_nxt == S_RUN);
            r_done     <= (w_state_nxt == S_DONE);
            r_pass     <= (w_state_nxt == S_DONE) &&
                          (w_err_cnt_nxt == '0) && w_cov_full_nxt;
        end
    end

`ifdef OR4_CHK_COVER_EN
    // Input-pattern coverage for the current run.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cov_mask <= '0;
            r_cov_full <= 1'b0;
        end else begin
            r_cov_mask <= w_cov_mask_nxt;
            r_cov_full <= w_cov_full_nxt;
        end
    end

    assign bus.cov_full = r_cov_full;
`else
    assign bus.cov_full = 1'b1;
`endif

    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.pass            = r_pass;
    assign bus.err_cnt         = r_err_cnt;
    assign bus.vec_cnt         = r_vec_cnt;
    assign bus.first_err_valid = r_fe_valid;
    assign bus.first_err_vec   = r_fe_vec;

endmodule

// File: tb/tb_or4_resp_checker.sv
// Directed bench for or4_resp_checker. Two checkers share one stimulus stream:
// the default ERR_W=8 instance and an ERR_W=2 instance for saturation.
module tb_or4_resp_checker;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    logic s_start    = 1'b0;
    logic s_in_valid = 1'b0;
    logic [3:0] s_vec = 4'd0;
    logic [2:0] s_efg = 3'd0;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef OR4_CHK_COVER_EN
    localparam logic COV_EN = 1'b1;
`else
    localparam logic COV_EN = 1'b0;
`endif

    localparam int MODE_GOLD  = 0;
    localparam int MODE_G_SA0 = 1;
    localparam int MODE_INV   = 2;

    or4_resp_checker_if #(.ERR_W(8)) u_if8 ();
    or4_resp_checker_if #(.ERR_W(2)) u_if2 ();

    assign u_if8.start    = s_start;
    assign u_if8.in_valid = s_in_valid;
    assign u_if8.a        = s_vec[3];
    assign u_if8.b        = s_vec[2];
    assign u_if8.c        = s_vec[1];
    assign u_if8.d        = s_vec[0];
    assign u_if8.e        = s_efg[2];
    assign u_if8.f        = s_efg[1];
    assign u_if8.g        = s_efg[0];
    assign u_if2.start    = s_start;
    assign u_if2.in_valid = s_in_valid;
    assign u_if2.a        = s_vec[3];
    assign u_if2.b        = s_vec[2];
    assign u_if2.c        = s_vec[1];
    assign u_if2.d        = s_vec[0];
    assign u_if2.e        = s_efg[2];
    assign u_if2.f        = s_efg[1];
    assign u_if2.g        = s_efg[0];

    or4_resp_checker #(.NVEC(16), .ERR_W(8)) u_dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (u_if8.slave)
    );

    or4_resp_checker #(.NVEC(16), .ERR_W(2)) u_dut_sat (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (u_if2.slave)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    // Expected OR-block response {E,F,G} for input vector {a,b,c,d}.
    function automatic logic [2:0] gold(input logic [3:0] v);
        return {v[3] | v[2], v[1] | v[0], |v};
    endfunction

    task automatic apply(input logic [3:0] v, input int mode, input logic vld, input logic st);
        s_vec      = v;
        s_in_valid = vld;
        s_start    = st;
        case (mode)
            MODE_G_SA0: s_efg = gold(v) & 3'b110;
            MODE_INV:   s_efg = ~gold(v);
            default:    s_efg = gold(v);
        endcase
        cyc();
    endtask

    task automatic idle();
        s_start    = 1'b0;
        s_in_valid = 1'b0;
        cyc();
    endtask

    task automatic sweep(input int mode);
        for (int i = 0; i < 16; i++) begin
            apply(4'(i), mode, 1'b1, 1'b0);
        end
        idle();
    endtask

    initial begin
        cyc();
        cyc();
        i_rst = 1'b0;

        // Reset values
        chk("rst_busy", 32'(u_if8.busy), 32'd0);
        chk("rst_done", 32'(u_if8.done), 32'd0);
        chk("rst_pass", 32'(u_if8.pass), 32'd0);
        chk("rst_err", 32'(u_if8.err_cnt), 32'd0);
        chk("rst_vec", 32'(u_if8.vec_cnt), 32'd0);
        chk("rst_fev", 32'(u_if8.first_err_valid), 32'd0);
        chk("rst_fevec", 32'(u_if8.first_err_vec), 32'd0);
        chk("rst_cov", 32'(u_if8.cov_full), COV_EN ? 32'd0 : 32'd1);

        // in_valid in IDLE is ignored
        apply(4'b1010, MODE_INV, 1'b1, 1'b0);
        chk("idle_vld_vec", 32'(u_if8.vec_cnt), 32'd0);
        chk("idle_vld_err", 32'(u_if8.err_cnt), 32'd0);
        chk("idle_vld_busy", 32'(u_if8.busy), 32'd0);

        // start with in_valid in IDLE: run starts, vector not counted
        apply(4'b1111, MODE_INV, 1'b1, 1'b1);
        chk("start_busy", 32'(u_if8.busy), 32'd1);
        chk("start_vec", 32'(u_if8.vec_cnt), 32'd0);
        chk("start_err", 32'(u_if8.err_cnt), 32'd0);

        // Golden sweep with a gap, and start pulsed mid-run
        for (int i = 0; i < 16; i++) begin
            apply(4'(i), MODE_GOLD, 1'b1, (i == 5));
            if (i == 7) begin
                idle();
                chk("gap_vec", 32'(u_if8.vec_cnt), 32'd8);
            end
            if (i == 14) begin
                chk("pre_last_done", 32'(u_if8.done), 32'd0);
                chk("pre_last_pass", 32'(u_if8.pass), 32'd0);
                chk("pre_last_vec", 32'(u_if8.vec_cnt), 32'd15);
                chk("pre_last_busy", 32'(u_if8.busy), 32'd1);
            end
        end
        chk("gold_done", 32'(u_if8.done), 32'd1);
        chk("gold_busy", 32'(u_if8.busy), 32'd0);
        chk("gold_pass", 32'(u_if8.pass), 32'd1);
        chk("gold_err", 32'(u_if8.err_cnt), 32'd0);
        chk("gold_vec", 32'(u_if8.vec_cnt), 32'd16);
        chk("gold_cov", 32'(u_if8.cov_full), 32'd1);
        chk("gold_fev", 32'(u_if8.first_err_valid), 32'd0);

        // in_valid in DONE ignored, verdict held
        apply(4'b0011, MODE_INV, 1'b1, 1'b0);
        idle();
        chk("done_hold", 32'(u_if8.done), 32'd1);
        chk("done_hold_pass", 32'(u_if8.pass), 32'd1);
        chk("done_vld_vec", 32'(u_if8.vec_cnt), 32'd16);
        chk("done_vld_err", 32'(u_if8.err_cnt), 32'd0);

        // G stuck-at-0 sweep; start from DONE with a bad vector alongside
        apply(4'b0110, MODE_INV, 1'b1, 1'b1);
        chk("restart_vec", 32'(u_if8.vec_cnt), 32'd0);
        chk("restart_done", 32'(u_if8.done), 32'd0);
        chk("restart_pass", 32'(u_if8.pass), 32'd0);
        sweep(MODE_G_SA0);
        chk("sa0_done", 32'(u_if8.done), 32'd1);
        chk("sa0_err", 32'(u_if8.err_cnt), 32'd15);
        chk("sa0_fev", 32'(u_if8.first_err_valid), 32'd1);
        chk("sa0_fevec", 32'(u_if8.first_err_vec), 32'b0001);
        chk("sa0_pass", 32'(u_if8.pass), 32'd0);
        chk("sa0_sat_err", 32'(u_if2.err_cnt), 32'd3);

        // Single pattern repeated: coverage incomplete when enabled
        apply(4'b0000, MODE_GOLD, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            apply(4'b0101, MODE_GOLD, 1'b1, 1'b0);
        end
        idle();
        chk("rep_done", 32'(u_if8.done), 32'd1);
        chk("rep_err", 32'(u_if8.err_cnt), 32'd0);
        chk("rep_cov", 32'(u_if8.cov_full), COV_EN ? 32'd0 : 32'd1);
        chk("rep_pass", 32'(u_if8.pass), COV_EN ? 32'd0 : 32'd1);
        chk("rep_fev", 32'(u_if8.first_err_valid), 32'd0);

        // Every vector fails: ERR_W=2 instance saturates
        apply(4'b0000, MODE_GOLD, 1'b0, 1'b1);
        sweep(MODE_INV);
        chk("inv_err8", 32'(u_if8.err_cnt), 32'd16);
        chk("inv_err2", 32'(u_if2.err_cnt), 32'd3);
        chk("inv_vec2", 32'(u_if2.vec_cnt), 32'd16);
        chk("inv_fevec", 32'(u_if8.first_err_vec), 32'b0000);
        chk("inv_fev", 32'(u_if8.first_err_valid), 32'd1);
        chk("inv_pass2", 32'(u_if2.pass), 32'd0);

        // Reset in the middle of a run with errors
        apply(4'b0000, MODE_GOLD, 1'b0, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            apply(4'(i), MODE_G_SA0, 1'b1, 1'b0);
        end
        chk("mid_vec", 32'(u_if8.vec_cnt), 32'd7);
        chk("mid_err", 32'(u_if8.err_cnt), 32'd7);
        s_in_valid = 1'b0;
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
        chk("abort_busy", 32'(u_if8.busy), 32'd0);
        chk("abort_done", 32'(u_if8.done), 32'd0);
        chk("abort_vec", 32'(u_if8.vec_cnt), 32'd0);
        chk("abort_err", 32'(u_if8.err_cnt), 32'd0);
        chk("abort_fev", 32'(u_if8.first_err_valid), 32'd0);
        chk("abort_fevec", 32'(u_if8.first_err_vec), 32'd0);

        apply(4'b0000, MODE_GOLD, 1'b0, 1'b1);
        sweep(MODE_GOLD);
        chk("post_vec", 32'(u_if8.vec_cnt), 32'd16);
        chk("post_err", 32'(u_if8.err_cnt), 32'd0);
        chk("post_fev", 32'(u_if8.first_err_valid), 32'd0);
        chk("post_pass", 32'(u_if8.pass), 32'd1);
        chk("post_pass2", 32'(u_if2.pass), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/or4_resp_checker.md
# or4_resp_checker

Synthesizable response checker for the four-input OR block (inputs A–D, outputs E/F/G). It is the receiving end of the OR-gate stimulus flow. Each valid cycle it samples the applied 4-bit input vector and the DUT's three outputs, then compares them against the golden functions. Over a run it accumulates the vector count, a saturating error count, the first failing vector and input-space coverage, and reports a registered pass/fail verdict. It sits beside the DUT on the lab board or in simulation, fed by any stimulus source.

## Interface
- NVEC, 16: vectors per run; range 1..31.
- ERR_W, 8: width of the error counter.

- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; 1-cycle pulse.
- in_valid  in  1  a/b/c/d/e/f/g are valid this cycle.
- a, b, c, d  in  1 each  stimulus applied to the DUT.
- e, f, g  in  1 each  DUT response.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next start or rst.
- pass  out  1  verdict; meaningful only while done=1.
- err_cnt  out  ERR_W  mismatching vectors; saturates at all-ones.
- vec_cnt  out  5  vectors checked in the current run.
- first_err_valid  out  1  first_err_vec holds a captured failure.
- first_err_vec  out  4  {a,b,c,d} of the first mismatching vector.
- cov_full  out  1  all 16 input patterns seen this run.

## Operation
- Golden functions: E = a|b; F = c|d; G = a|b|c|d.
- A vector mismatches when any of e, f, g differs from its golden value.
- FSM states are IDLE, RUN and DONE. Reset enters IDLE.
- IDLE -> RUN on start. On this transition, clear err_cnt, vec_cnt, first_err_*, and the coverage mask.
- RUN: each in_valid cycle increments vec_cnt and sets coverage bit {a,b,c,d}.
  - If the vector mismatches, err_cnt increments, holding at 2^ERR_W-1.
  - On the first mismatch of the run, capture first_err_vec and set first_err_valid.
- RUN -> DONE on the cycle the NVEC-th valid vector is accepted.
- DONE -> RUN on start, with the same clearing as IDLE -> RUN.
- pass = (err_cnt == 0) && cov_full. It is evaluated in DONE only and is 0 in IDLE and RUN.
- busy = (state == RUN); done = (state == DONE).

## Timing
- Reset values: busy=0, done=0, pass=0, err_cnt=0, vec_cnt=0, first_err_valid=0, first_err_vec=0, cov_full=0.
- All outputs are registered. A vector accepted at edge N is reflected in err_cnt, vec_cnt, cov_full and first_err_* after edge N.
- done and pass assert on the edge that accepts the NVEC-th vector; that final vector is included in the verdict.
- start and in_valid in the same IDLE or DONE cycle: the run starts and that vector is not counted.
- start during RUN is ignored.
- in_valid in IDLE or DONE is ignored; no counter changes.
- rst during RUN clears everything at the next edge and returns to IDLE. No partial verdict is produced.
- Gaps in in_valid are allowed. No timeout exists; the run waits indefinitely.
- Coverage requires NVEC ≥ 16. With NVEC < 16, cov_full and therefore pass cannot assert while the macro below is defined.

## Configuration
- OR4_CHK_COVER_EN defined: the 16-bit coverage mask is built, cov_full reflects it, and pass requires full coverage.
- OR4_CHK_COVER_EN undefined: no mask is built, cov_full is tied to 1, and pass = (err_cnt == 0) in DONE.

## Test plan
- Golden DUT, NVEC=16, all 16 patterns 0000..1111 on consecutive cycles -> done=1, pass=1, err_cnt=0, vec_cnt=16, cov_full=1, first_err_valid=0.
- Same sweep with G stuck-at-0 -> fails on vectors 0001..1111 (pattern 0000 still passes, expected G=0) -> err_cnt=15, first_err_vec=4'b0001, pass=0.
- Golden DUT, pattern 0101 repeated 16 times -> err_cnt=0, cov_full=0, pass=0. With the macro undefined -> pass=1.
- ERR_W=2, all vectors fail -> err_cnt saturates at 3, vec_cnt=16.
- rst asserted after 7 vectors, then start and a full sweep -> vec_cnt=16, no carry-over from the aborted run, pass=1.
- start pulsed in RUN, and in_valid pulsed in IDLE -> no effect on state or counters.
